pattern_gen_param: RTL and testbench

//  Next-generation test-pattern source for the rgb2dvi HDMI path. It generates parametrised

---
 rtl/pattern_gen_param_pkg.sv | 28 ++
 rtl/pattern_gen_param_timing.sv | 102 ++++++++++
 rtl/pattern_gen_param.sv | 189 ++++++++++++++++++
 tb/tb_pattern_gen_param.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_gen_param_pkg.sv
// Shared types and constants for the parametrised test-pattern generator.
//   mode_e   : pattern selector values
//   BAR_LUT  : 8-entry {R,G,B} on/off table for the colour bars
//   rgb_w    : packed pixel width for a given channel width
package pattern_gen_param_pkg;

  typedef enum logic [2:0] {
    MODE_SOLID  = 3'd0,
    MODE_BARS   = 3'd1,
    MODE_RAMP   = 3'd2,
    MODE_CHECK  = 3'd3,
    MODE_SCROLL = 3'd4
  } mode_e;

  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [2:0] BAR_LUT [8] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

  function automatic int rgb_w(input int color_w);
    return 3 * color_w;
  endfunction

  function automatic logic [2:0] bar_lut(input logic [2:0] idx);
    return BAR_LUT[idx];
  endfunction

endpackage

// File: rtl/pattern_gen_param_timing.sv
// Video timing generator: h/v counters plus the first pipeline stage
// (registered DE, HS, VS, frame-start and pixel coordinates).
//   clk_i, rst_ni : pixel clock, async active-low reset
//   en_i          : 1 = run, 0 = counters held at 0 and stage outputs idle
//   sof_o         : combinational, counters sit on (0,0) while enabled
//   x_o, y_o      : registered pixel coordinates
//   de_o, hs_o, vs_o, fs_o : registered decode, aligned with x_o/y_o
module pattern_gen_param_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  output logic          sof_o,
  output logic [HW-1:0] x_o,
  output logic [VW-1:0] y_o,
  output logic          de_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic          fs_o
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [31:0] HA_U  = 32'(H_ACTIVE);
  localparam logic [31:0] VA_U  = 32'(V_ACTIVE);
  localparam logic [31:0] HS0_U = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS1_U = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS0_U = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS1_U = 32'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [31:0]   h_w, v_w;
  logic          h_last;
  logic          de_c, hs_c, vs_c;

  always_comb begin
    h_last = (h_q == HW'(H_TOT - 1));
    h_d    = h_last ? '0 : h_q + 1'b1;
    v_d    = v_q;
    if (h_last) begin
      v_d = (v_q == VW'(V_TOT - 1)) ? '0 : v_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else if (!en_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Compare in 32 bits so sync windows that end exactly at the total
  // (zero back porch) cannot overflow the counter width.
  assign h_w = 32'(h_q);
  assign v_w = 32'(v_q);

  // VS depends only on v, which only moves on the h wrap, so its edges
  // land on h=0 without extra logic.
  assign de_c  = en_i && (h_w < HA_U) && (v_w < VA_U);
  assign hs_c  = en_i && (h_w >= HS0_U) && (h_w < HS1_U);
  assign vs_c  = en_i && (v_w >= VS0_U) && (v_w < VS1_U);
  assign sof_o = en_i && (h_q == '0) && (v_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_o  <= '0;
      y_o  <= '0;
      de_o <= 1'b0;
      hs_o <= ~HS_POL;
      vs_o <= ~VS_POL;
      fs_o <= 1'b0;
    end else begin
      x_o  <= h_q;
      y_o  <= v_q;
      de_o <= de_c;
      hs_o <= hs_c ? HS_POL : ~HS_POL;
      vs_o <= vs_c ? VS_POL : ~VS_POL;
      fs_o <= sof_o;
    end
  end

endmodule

// File: rtl/pattern_gen_param.sv
// Parametrised test-pattern source for an rgb2dvi-style HDMI path.
// Stage 1 (timing sub-module) decodes counters; stage 2 (here) computes the
// colour and re-registers sync/DE/frame-start so all pins are aligned,
// two clocks after counter state.
//   clk_i, rst_ni      : pixel clock, async active-low reset
//   en_i               : 1 = run timing, 0 = idle
//   mode_i             : pattern select, latched at frame start
//   solid_rgb_i        : {R,G,B} for solid mode, sampled live
//   vga_r/g/b_o        : pixel colour, 0 outside active video
//   vga_hs_o, vga_vs_o : syncs with configurable polarity
//   vga_de_o           : active-video enable
//   frame_start_o      : one-cycle pulse with pixel (0,0)
//   frame_cnt_o        : index of the frame currently being produced
module pattern_gen_param
  import pattern_gen_param_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int COLOR_W     = 8,
  parameter int CHECK_LOG2  = 5,
  parameter int SCROLL_STEP = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        en_i,
  input  logic [2:0]                  mode_i,
  input  logic [rgb_w(COLOR_W)-1:0]   solid_rgb_i,
  output logic [COLOR_W-1:0]          vga_r_o,
  output logic [COLOR_W-1:0]          vga_g_o,
  output logic [COLOR_W-1:0]          vga_b_o,
  output logic                        vga_hs_o,
  output logic                        vga_vs_o,
  output logic                        vga_de_o,
  output logic                        frame_start_o,
  output logic [15:0]                 frame_cnt_o
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int RGB_W = rgb_w(COLOR_W);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int XW    = (HW > COLOR_W) ? HW : COLOR_W;

  localparam logic [HW:0] HA_X   = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0] STEP_X = (HW+1)'(SCROLL_STEP);

  logic          sof;
  logic [HW-1:0] x1;
  logic [VW-1:0] y1;
  logic          de1, hs1, vs1, fs1;

  pattern_gen_param_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HS_POL   (HS_POL),
    .VS_POL   (VS_POL),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (en_i),
    .sof_o  (sof),
    .x_o    (x1),
    .y_o    (y1),
    .de_o   (de1),
    .hs_o   (hs1),
    .vs_o   (vs1),
    .fs_o   (fs1)
  );

  // Per-frame state. The running counters hold the value for the *next*
  // frame; the _cur copies are snapshotted at frame start so the frame in
  // flight uses frame_cnt/scroll as they stood when it began (frame 0
  // after reset sees 0 for both).
  logic [2:0]    mode_q;
  logic [15:0]   frame_cnt_q, frame_cur_q;
  logic [HW-1:0] scroll_q, scroll_cur_q, scroll_d;
  logic [HW:0]   scroll_sum;

  always_comb begin
    scroll_sum = {1'b0, scroll_q} + STEP_X;
    scroll_d   = (scroll_sum >= HA_X) ? HW'(scroll_sum - HA_X) : HW'(scroll_sum);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q       <= 3'd0;
      frame_cnt_q  <= '0;
      frame_cur_q  <= '0;
      scroll_q     <= '0;
      scroll_cur_q <= '0;
    end else if (sof) begin
      mode_q       <= mode_i;
      frame_cur_q  <= frame_cnt_q;
      frame_cnt_q  <= frame_cnt_q + 16'd1;
      scroll_cur_q <= scroll_q;
      scroll_q     <= scroll_d;
    end
  end

  assign frame_cnt_o = frame_cur_q;

  // Bar index by comparing against constant bar boundaries, no divider.
  function automatic logic [2:0] bar_idx(input logic [HW:0] xx);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (xx >= (HW+1)'(k * BAR_W)) idx = 3'(k);
    end
    return idx;
  endfunction

  function automatic logic [RGB_W-1:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] on;
    on = bar_lut(idx);
    return {{COLOR_W{on[2]}}, {COLOR_W{on[1]}}, {COLOR_W{on[0]}}};
  endfunction

  logic [HW:0]        xs_sum, xs;
  logic [HW-1:0]      x_sh;
  logic [VW-1:0]      y_sh;
  logic               chk_on;
  logic [XW-1:0]      x_ext;
  logic [COLOR_W-1:0] ramp;
  logic [RGB_W-1:0]   rgb_d;

  always_comb begin
    // scroll_cur_q < H_ACTIVE and x < H_ACTIVE, so one subtraction wraps.
    xs_sum = {1'b0, x1} + {1'b0, scroll_cur_q};
    xs     = (xs_sum >= HA_X) ? xs_sum - HA_X : xs_sum;
    x_sh   = x1 >> CHECK_LOG2;
    y_sh   = y1 >> CHECK_LOG2;
    chk_on = x_sh[0] ^ y_sh[0] ^ frame_cur_q[5];
    x_ext  = XW'(x1);
    ramp   = x_ext[COLOR_W-1:0];
  end

  always_comb begin
    rgb_d = '0;
    if (de1) begin
      case (mode_e'(mode_q))
        MODE_SOLID:  rgb_d = solid_rgb_i;
        MODE_BARS:   rgb_d = bar_rgb(bar_idx({1'b0, x1}));
        MODE_RAMP:   rgb_d = {3{ramp}};
        MODE_CHECK:  rgb_d = chk_on ? '1 : '0;
        MODE_SCROLL: rgb_d = bar_rgb(bar_idx(xs));
        default:     rgb_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vga_r_o       <= '0;
      vga_g_o       <= '0;
      vga_b_o       <= '0;
      vga_hs_o      <= ~HS_POL;
      vga_vs_o      <= ~VS_POL;
      vga_de_o      <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      vga_r_o       <= rgb_d[3*COLOR_W-1:2*COLOR_W];
      vga_g_o       <= rgb_d[2*COLOR_W-1:COLOR_W];
      vga_b_o       <= rgb_d[COLOR_W-1:0];
      vga_hs_o      <= hs1;
      vga_vs_o      <= vs1;
      vga_de_o      <= de1;
      frame_start_o <= fs1;
    end
  end

endmodule

// File: tb/tb_pattern_gen_param.sv
module tb_pattern_gen_param;

  // Small geometry for the scoreboarded instance so many frames fit.
  localparam int HA = 64, HFP = 2, HSY = 4, HBP = 2, HT = HA + HFP + HSY + HBP;
  localparam int VA = 16, VFP = 1, VSY = 2, VBP = 1, VT = VA + VFP + VSY + VBP;
  localparam int STEP = 24, CL2 = 3;
  localparam logic [27:0] IDLE = 28'h0000006;

  logic        clk = 1'b0;
  logic        rst_n, en, en2;
  logic [2:0]  mode_in, mode2;
  logic [23:0] solid;

  logic [7:0]  r, g, b, r2, g2, b2;
  logic        hs, vs, de, fs, hs2, vs2, de2, fs2;
  logic [15:0] fcnt, fcnt2;
  logic [27:0] dut_vec, dut2_vec;

  always #5 clk = ~clk;

  pattern_gen_param #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(8), .CHECK_LOG2(CL2), .SCROLL_STEP(STEP)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mode_i(mode_in), .solid_rgb_i(solid),
    .vga_r_o(r), .vga_g_o(g), .vga_b_o(b), .vga_hs_o(hs), .vga_vs_o(vs),
    .vga_de_o(de), .frame_start_o(fs), .frame_cnt_o(fcnt)
  );

  // Default 640x480 geometry, used for line-level timing and bar positions.
  pattern_gen_param dut_vga (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en2), .mode_i(mode2), .solid_rgb_i(solid),
    .vga_r_o(r2), .vga_g_o(g2), .vga_b_o(b2), .vga_hs_o(hs2), .vga_vs_o(vs2),
    .vga_de_o(de2), .frame_start_o(fs2), .frame_cnt_o(fcnt2)
  );

  assign dut_vec  = {r, g, b, de, hs, vs, fs};
  assign dut2_vec = {r2, g2, b2, de2, hs2, vs2, fs2};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] bar_color(input int x);
    int idx;
    idx = x / (HA / 8);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [27:0] model_px(input int h, input int v, input int md,
                                           input int fr, input logic [23:0] sol);
    logic [23:0] rgb;
    logic [7:0]  lo;
    logic        pde, phs, pvs, pfs;
    int          scr;
    pde = (h < HA) && (v < VA);
    phs = !((h >= HA + HFP) && (h < HA + HFP + HSY));
    pvs = !((v >= VA + VFP) && (v < VA + VFP + VSY));
    pfs = (h == 0) && (v == 0);
    rgb = 24'h0;
    lo  = h[7:0];
    scr = (fr * STEP) % HA;
    if (pde) begin
      case (md)
        0: rgb = sol;
        1: rgb = bar_color(h);
        2: rgb = {lo, lo, lo};
        3: rgb = ((((h >> CL2) ^ (v >> CL2) ^ (fr >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
        4: rgb = bar_color((h + scr) % HA);
        default: rgb = 24'h0;
      endcase
    end
    return {rgb, pde, phs, pvs, pfs};
  endfunction

  typedef struct {
    logic [27:0] exp;
    int h;
    int v;
    int fr;
    int md;
  } sb_t;

  sb_t q[$];
  int mh, mv, frame_idx, cur_fr, mode_lat;

  // One pixel clock: compare the entry produced two clocks ago, push the
  // expectation for the current counter position, advance the model.
  task automatic cycle();
    sb_t e;
    if (q.size() >= 2) begin
      e = q.pop_front();
      chk($sformatf("pix f%0d m%0d h%0d v%0d", e.fr, e.md, e.h, e.v), dut_vec, e.exp);
      if (e.md == 4 && e.fr == 3 && e.h == 0 && e.v == 0)
        chk("scroll_f3_px0", dut_vec[27:4], 24'hFFFF00);
      if (e.md == 2 && e.h == 5 && e.v == 0)
        chk("ramp_px5", dut_vec[27:4], 24'h050505);
      if (e.md == 1 && e.fr == 6 && e.h == 8 && e.v == 10)
        chk("latch_bars_hold", dut_vec[27:4], 24'hFFFF00);
    end else begin
      chk("pipe_fill_idle", dut_vec, IDLE);
    end
    if (mh == 0 && mv == 0) begin
      mode_lat = int'(mode_in);
      cur_fr   = frame_idx;
      frame_idx++;
    end
    e.exp = model_px(mh, mv, mode_lat, cur_fr, solid);
    e.h = mh; e.v = mv; e.fr = cur_fr; e.md = mode_lat;
    q.push_back(e);
    @(negedge clk);
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv++;
      if (mv == VT) mv = 0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic model_reset();
    q.delete();
    mh = 0; mv = 0; frame_idx = 0; cur_fr = 0; mode_lat = 0;
  endtask

  initial begin
    int  wait_cnt, de_cnt, de_fall, hs_first, hs_cnt;
    logic found, de_next;
    logic [23:0] p0, p79, p80, p320, p639;

    rst_n = 1'b0; en = 1'b1; en2 = 1'b0;
    mode_in = 3'd4; mode2 = 3'd1; solid = 24'h123456;
    model_reset();

    repeat (5) @(negedge clk);
    chk("rst_idle", dut_vec, IDLE);
    chk("rst_idle_vga", dut2_vec, IDLE);

    rst_n = 1'b1; en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("en0_idle", dut_vec, IDLE);
      chk("en0_idle_vga", dut2_vec, IDLE);
    end
    chk("en0_frame_cnt", fcnt, 16'd0);

    // frames 0..3 scroll (scroll 0,24,48,8)
    en = 1'b1;
    run(4 * HT * VT);
    chk("frame_cnt_after_scroll", fcnt, 16'd3);

    // frames 4..5 bars
    mode_in = 3'd1;
    run(2 * HT * VT);

    // switch to ramp at line 3 of frame 6: frame 6 stays bars, frame 7 ramp
    run(3 * HT + 10);
    mode_in = 3'd2;
    run(2 * HT * VT);

    // checker until frame_cnt bit 5 has toggled
    mode_in = 3'd3;
    for (int i = 0; i < 40 * HT * VT && frame_idx < 35; i++) cycle();
    chk("checker_reached_f34", frame_idx, 35);
    chk("frame_cnt_f34", fcnt, 16'(cur_fr));
    run(HT * 3);

    // solid
    mode_in = 3'd0;
    run(2 * HT * VT);

    // checker again, then reset mid-line
    mode_in = 3'd3;
    run(HT * VT);
    found = 1'b0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      if (mh == 30 && mv == 1) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    chk("reset_point_found", found, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_idle", dut_vec, IDLE);
    chk("async_rst_frame_cnt", fcnt, 16'd0);
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_hold_idle", dut_vec, IDLE);
    rst_n = 1'b1;
    run(200);
    chk("frame_cnt_restart", fcnt, 16'd0);
    run(HT * VT);
    chk("frame_cnt_after_restart", fcnt, 16'd1);

    // 640x480 line checks on the default-parameter instance
    en2 = 1'b1;
    found = 1'b0;
    wait_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      wait_cnt++;
      if (fs2) begin
        found = 1'b1;
        break;
      end
    end
    chk("vga_fs_seen", found, 1'b1);
    chk("vga_fs_latency", wait_cnt, 2);
    de_cnt = 0; de_fall = -1; hs_first = -1; hs_cnt = 0; de_next = 1'b0;
    p0 = '0; p79 = '0; p80 = '0; p320 = '0; p639 = '0;
    for (int k = 0; k <= 800; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 800) begin
        if (de2) de_cnt++;
        if (!de2 && de_fall < 0) de_fall = k;
        if (!hs2) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = k;
        end
        if (k == 0)   p0   = {r2, g2, b2};
        if (k == 79)  p79  = {r2, g2, b2};
        if (k == 80)  p80  = {r2, g2, b2};
        if (k == 320) p320 = {r2, g2, b2};
        if (k == 639) p639 = {r2, g2, b2};
      end else begin
        de_next = de2;
      end
    end
    chk("vga_de_count", de_cnt, 640);
    chk("vga_de_fall", de_fall, 640);
    chk("vga_hs_start", hs_first, 656);
    chk("vga_hs_width", hs_cnt, 96);
    chk("vga_line_period", de_next, 1'b1);
    chk("vga_px0", p0, 24'hFFFFFF);
    chk("vga_px79", p79, 24'hFFFFFF);
    chk("vga_px80", p80, 24'hFFFF00);
    chk("vga_px320", p320, 24'hFF00FF);
    chk("vga_px639", p639, 24'h000000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
